alu_issue_queue: RTL and testbench
==================================

# alu_issue_queue

Command-buffering stage that sits directly upstream of the 8-bit combinational ALU.

- Accepts operand/opcode commands over a valid/ready handshake and holds them in a small FIFO.
- Presents the FIFO head on the ALU's A/B/Op inputs.
- Registers the ALU's Result, plus the opcode and a zero flag, into an output stage with its own valid/ready handshake.
- Decouples the producer from the result consumer so the ALU can be fed back-to-back without stalls.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  command present.
- in_ready  out  1  queue can accept (not full).
- in_a  in  8  operand A.
- in_b  in  8  operand B.
- in_op  in  3  opcode 0..7 (ADD, SUB, NOT, NAND, NOR, AND, OR, XOR).
- alu_a  out  8  to ALU A.
- alu_b  out  8  to ALU B.
- alu_op  out  3  to ALU Op.
- alu_result  in  8  from ALU Result (combinational).
- out_valid  out  1  result register holds data.
- out_ready  in  1  consumer accepts result.
- out_result  out  8  registered result.
- out_op  out  3  opcode that produced out_result.
- out_zero  out  1  high when out_result == 8'h00.

## Operation
- Push: on a rising edge where in_valid && in_ready, write {in_a, in_b, in_op} at the write pointer and increment it.
- in_ready = (count != DEPTH). It does not depend on a same-cycle pop: a full queue refuses input even while popping.
- Head drive:
  - When count != 0, alu_a/alu_b/alu_op = head entry.
  - When empty, drive 0/0/0.
- Issue/pop condition: count != 0 && (!out_valid || out_ready).
- On issue:
  - Capture alu_result → out_result, head op → out_op, (alu_result == 0) → out_zero.
  - Set out_valid and advance the read pointer.
- If out_valid && out_ready and the queue is empty, clear out_valid. out_result/out_op/out_zero hold their last values.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Arithmetic is done only by the ALU and is 8-bit modulo; no carry or overflow is visible here.
- Total capacity is DEPTH + 1 commands: DEPTH in the FIFO plus one in the output register.
- Reset values:
  - count = 0, pointers = 0, in_ready = 1.
  - out_valid = 0, out_result = 8'h00, out_op = 3'd0, out_zero = 0.
  - alu_a = alu_b = 0, alu_op = 0.
  - FIFO storage does not need a reset.
- Reset mid-operation: all queued and unconsumed results are discarded immediately (asynchronous) and nothing is replayed.

## Timing
- Accept at edge E0 → head is visible on alu_* after E0 → captured at E1 → out_valid high after E1, provided the queue was empty and the output register was free or being consumed. Minimum latency is one clock.
- Throughput: one result per clock when out_ready is held high.
- out_ready low: out_* are stable and the head stays on alu_*.
- Combinational path: FIFO head → ALU → alu_result → output register, all within one cycle.
- There are no combinational paths from out_ready or in_valid to any output.

## Configuration
- ALU_ISSUE_STATS_EN
  - Defined: adds output port issue_count [15:0], reset 16'h0000. It increments on every issue and saturates at 16'hFFFF.
  - Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package alu_pkg holds:
  - ALU_W = 8, OP_W = 3.
  - Opcode enum alu_op_e with ADD = 0, SUB = 1, NOT = 2, NAND = 3, NOR = 4, AND = 5, OR = 6, XOR = 7.
  - Packed struct alu_cmd_t {a, b, op}.
- Sub-module alu_cmd_fifo is a generic DEPTH-entry FIFO of alu_cmd_t with count/full/empty outputs. The top level owns only the output register, the handshakes and the stats counter.

## Test plan
- Reset, then push {7F, 01, ADD} with out_ready = 1 → one clock later out_valid = 1, out_result = 80, out_op = 0, out_zero = 0.
- Push {FF, 01, ADD}, then {05, 05, SUB} back-to-back → results 00 (zero = 1), then 00 (zero = 1) on consecutive cycles; ordering is preserved.
- out_ready = 0, push 6 commands continuously at DEPTH = 4 → exactly 5 accepted, in_ready low after the 5th. Then release out_ready → 5 results in order, one per clock, and in_ready rises one clock after the first pop.
- Streaming across pointer wrap: 10 commands {i, 3, XOR} with a random out_ready pattern → out_result = i ^ 3 in order, with no loss or duplication.
- Assert rst while 3 commands are queued and out_valid = 1 → immediately out_valid = 0, in_ready = 1, alu_* = 0; after release, no stale results appear.
- With ALU_ISSUE_STATS_EN defined: 7 issues → issue_count = 7. Force the counter to FFFE and issue 3 → issue_count = FFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue path: operand/opcode widths, opcode encoding
// and the queued command record.
package alu_pkg;

  localparam int ALU_W = 8;
  localparam int OP_W  = 3;

  typedef enum logic [OP_W-1:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    NOT  = 3'd2,
    NAND = 3'd3,
    NOR  = 3'd4,
    AND  = 3'd5,
    OR   = 3'd6,
    XOR  = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    alu_op_e          op;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// DEPTH-entry FIFO of ALU commands; the head reads as all-zero while empty so
// the downstream ALU sees a quiet input.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  alu_cmd_t                 cmd,
  input  logic                     pop,
  output alu_cmd_t                 head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  alu_cmd_t           mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // Push is refused whenever full, even if a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= cmd;
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Buffers ALU commands, presents the head to the combinational ALU and
// registers its result. Optional issue counter: define ALU_ISSUE_STATS_EN.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic [2:0]  in_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic [7:0]  alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_result,
  output logic [2:0]  out_op,
  output logic        out_zero
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0] issue_count
`endif
);

  alu_cmd_t               cmd;
  alu_cmd_t               head;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;
  logic                   issue;

  assign cmd.a  = in_a;
  assign cmd.b  = in_b;
  assign cmd.op = alu_op_e'(in_op);

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .cmd   (cmd),
    .pop   (issue),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign in_ready = !full;
  assign alu_a    = head.a;
  assign alu_b    = head.b;
  assign alu_op   = head.op;
  assign issue    = !empty && (!out_valid || out_ready);

  // Stage boundary: ALU result captured into the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_op     <= '0;
      out_zero   <= 1'b0;
    end else if (issue) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_op     <= alu_op;
      out_zero   <= (alu_result == 8'h00);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issue_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
    end else if (issue && (issue_cnt != 16'hFFFF)) begin
      issue_cnt <= issue_cnt + 16'd1;
    end
  end

  assign issue_count = issue_cnt;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: behavioural ALU on alu_*, scoreboard
// of expected results, table vectors plus backpressure, wrap and reset cases.
module tb_alu_issue_queue;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [2:0] out_op;
  logic       out_zero;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issue_count;
`endif

  alu_issue_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .out_zero   (out_zero)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .issue_count(issue_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU standing in for the real combinational unit.
  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = ~alu_a;
      3'd3: alu_result = ~(alu_a & alu_b);
      3'd4: alu_result = ~(alu_a | alu_b);
      3'd5: alu_result = alu_a & alu_b;
      3'd6: alu_result = alu_a | alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic [2:0] op;
  } sb_t;

  sb_t        sb[$];
  vec_t       vecs[9];
  logic [7:0] cur_exp;
  int         compared   = 0;
  int         mismatched = 0;
  int         popped     = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Transfers are decided at the coming rising edge; sample them mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_result: got %0h expected none", out_result);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("out_result", {24'h0, out_result}, {24'h0, e.res});
          chk("out_op", {29'h0, out_op}, {29'h0, e.op});
          chk("out_zero", {31'h0, out_zero}, {31'h0, (e.res == 8'h00)});
        end
        popped++;
      end
      if (in_valid && in_ready) sb.push_back('{res: cur_exp, op: in_op});
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic [7:0] exp);
    int t;
    in_a = a; in_b = b; in_op = op; cur_exp = exp; in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int acc;
    int p;
    vecs[0] = '{8'h7F, 8'h01, ADD,  8'h80};
    vecs[1] = '{8'hFF, 8'h01, ADD,  8'h00};
    vecs[2] = '{8'h05, 8'h05, SUB,  8'h00};
    vecs[3] = '{8'h0F, 8'h00, NOT,  8'hF0};
    vecs[4] = '{8'hF0, 8'h0F, NAND, 8'hFF};
    vecs[5] = '{8'hF0, 8'h0F, NOR,  8'h00};
    vecs[6] = '{8'hFF, 8'h0F, AND,  8'h0F};
    vecs[7] = '{8'hF0, 8'h0F, OR,   8'hFF};
    vecs[8] = '{8'hAA, 8'hFF, XOR,  8'h55};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    out_ready = 1'b1; cur_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_alu_a", {24'h0, alu_a}, 32'h0);
    chk("rst_out_result", {24'h0, out_result}, 32'h0);
    chk("rst_out_zero", {31'h0, out_zero}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Minimum latency: accepted at E0, result valid after E1.
    send(8'h7F, 8'h01, ADD, 8'h80);
    chk("lat_not_yet_valid", {31'h0, out_valid}, 32'h0);
    chk("lat_head_a", {24'h0, alu_a}, 32'h7F);
    @(posedge clk); #1;
    chk("lat_out_valid", {31'h0, out_valid}, 32'h1);
    chk("lat_out_result", {24'h0, out_result}, 32'h80);
    drain();

    for (int i = 0; i < 9; i++) send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
    drain();

    // Backpressure: five of six are taken (four queued plus the output register).
    out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_a = 8'(k + 1); in_b = 8'h10; in_op = ADD; cur_exp = 8'(k + 8'h11);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc, 32'd5);
    chk("bp_in_ready_full", {31'h0, in_ready}, 32'h0);
    chk("bp_head_stable", {24'h0, alu_a}, 32'h2);
    p = popped;
    out_ready = 1'b1;
    chk("bp_in_ready_before_pop", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    chk("bp_in_ready_after_pop", {31'h0, in_ready}, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drained", popped - p, 32'd5);
    chk("bp_out_valid_clear", {31'h0, out_valid}, 32'h0);

    // Streaming across pointer wrap with random consumer stalls.
    p = popped;
    fork
      for (int i = 0; i < 10; i++) send(8'(i), 8'h03, XOR, 8'(i) ^ 8'h03);
      begin
        repeat (40) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("wrap_count", popped - p, 32'd10);

    // Asynchronous reset with one result held and three commands queued.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(i + 8'h20), 8'h01, ADD, 8'(i + 8'h21));
    chk("pre_rst_out_valid", {31'h0, out_valid}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    chk("arst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("arst_alu_a", {24'h0, alu_a}, 32'h0);
    chk("arst_alu_op", {29'h0, alu_op}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    p = popped;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_no_stale", popped - p, 32'd0);
    chk("post_rst_out_valid", {31'h0, out_valid}, 32'h0);

`ifdef ALU_ISSUE_STATS_EN
    do_reset();
    for (int i = 0; i < 7; i++) send(8'(i), 8'h01, AND, 8'(i) & 8'h01);
    drain();
    chk("stats_seven", {16'h0, issue_count}, 32'd7);
    @(negedge clk);
    force dut.issue_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.issue_cnt;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send(8'(i), 8'h02, OR, 8'(i) | 8'h02);
    drain();
    chk("stats_saturate", {16'h0, issue_count}, 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
